// File: rtl/constants_pkg.sv
// Shared widths and arbitration types for the cache/memory interface.
package constants_pkg;

    localparam int unsigned ARCH_LEN = 32;
    localparam int unsigned ICLLEN   = 128;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the side that did not win last time is chosen.
module rr_arbiter2
    import constants_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  grant_t last_grant,
    output grant_t grant,
    output logic   valid
);

    always_comb begin
        valid = req_i | req_d;
        grant = GRANT_I;
        if (req_i && req_d) begin
            grant = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
        end else if (req_d) begin
            grant = GRANT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache refills and dcache line accesses,
// with round-robin arbitration, grant-time latching and an ack watchdog.
module mem_arbiter #(
    parameter int unsigned ARCH_LEN = constants_pkg::ARCH_LEN,
    parameter int unsigned LINE_LEN = constants_pkg::ICLLEN,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ARCH_LEN-1:0] i_addr,
    output logic                i_ready,
    output logic [LINE_LEN-1:0] i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ARCH_LEN-1:0] d_addr,
    input  logic [LINE_LEN-1:0] d_wdata,
    output logic                d_ready,
    output logic [LINE_LEN-1:0] d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ARCH_LEN-1:0] mem_addr,
    output logic [LINE_LEN-1:0] mem_wdata,
    input  logic                mem_ack,
    input  logic [LINE_LEN-1:0] mem_rdata,
    output logic                err
);

    import constants_pkg::*;

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t      state, state_d;
    grant_t          last_grant, last_grant_d;
    grant_t          arb_grant;
    logic            arb_valid;
    logic [WD_W-1:0] wd, wd_d;
    logic            err_d;
    logic            grab;

    rr_arbiter2 u_rr (
        .req_i      (i_req),
        .req_d      (d_req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    assign mem_req = (state != IDLE);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        wd_d         = wd;
        err_d        = err;
        grab         = 1'b0;
        i_ready      = 1'b0;
        d_ready      = 1'b0;
        unique case (state)
            IDLE: begin
                if (arb_valid) begin
                    grab         = 1'b1;
                    last_grant_d = arb_grant;
                    wd_d         = '0;
                    state_d      = (arb_grant == GRANT_I) ? SERVE_I : SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                // A completing ack takes priority over an expiring watchdog.
                if (mem_ack) begin
                    i_ready = (state == SERVE_I);
                    d_ready = (state == SERVE_D);
                    state_d = IDLE;
                end else if ((TIMEOUT != 0) && (wd == WD_LAST)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
            wd         <= '0;
            err        <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            wd         <= wd_d;
            err        <= err_d;
            if (grab) begin
                if (arb_grant == GRANT_I) begin
                    mem_we    <= 1'b0;
                    mem_addr  <= i_addr;
                    mem_wdata <= '0;
                end else begin
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end
            end
        end
    end

endmodule
